// File: rtl/neo_pattern_gen.sv
// neo_pattern_gen: loads every colour byte of a NeoPixel frame, requests a send, idles a gap.
// Optional brightness right-shift by dim_shift when DIM_EN is defined.
module neo_pattern_gen #(
    parameter int NUM_PIXELS = 8,
    parameter int COLOR_W    = 8,
    parameter int PIX_W      = $clog2(NUM_PIXELS),
    parameter int GAP_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] base_level,
    input  logic [GAP_W-1:0]   gap_cycles,
    input  logic [2:0]         dim_shift,
    input  logic               ready_to_load,
    input  logic               ready_to_send,
    output logic [PIX_W-1:0]   pixel_index,
    output logic [1:0]         color_index,
    output logic [COLOR_W-1:0] color_level,
    output logic               load_color,
    output logic               send_it,
    output logic               frame_done,
    output logic [15:0]        phase
);

    typedef enum logic [1:0] {IDLE, LOAD, SENDWAIT, GAP} state_t;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         mode_q;
    logic [COLOR_W-1:0] base_q;
    logic [PIX_W-1:0]   pix_cnt;
    logic [1:0]         col_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [15:0]        phase_q;

    logic take_load;
    logic last_write;
    logic take_send;
    logic gap_done;
    logic frame_start;

    assign take_load   = (state == LOAD) && ready_to_load;
    assign last_write  = take_load && (pix_cnt == PIX_W'(NUM_PIXELS - 1))
                         && (col_cnt == 2'd2);
    assign take_send   = (state == SENDWAIT) && ready_to_send;
    assign gap_done    = (state == GAP) && (gap_cnt == '0);
    assign frame_start = enable && ((state == IDLE) || gap_done);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (enable) state_nx = LOAD;
            LOAD:     if (last_write) state_nx = SENDWAIT;
            SENDWAIT: if (ready_to_send) state_nx = GAP;
            GAP:      if (gap_cnt == '0) state_nx = enable ? LOAD : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Frame settings are captured only at frame start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q  <= '0;
            base_q  <= '0;
            pix_cnt <= '0;
            col_cnt <= '0;
            gap_cnt <= '0;
            phase_q <= '0;
        end else begin
            if (frame_start) begin
                mode_q  <= mode;
                base_q  <= base_level;
                pix_cnt <= '0;
                col_cnt <= '0;
            end else if (take_load) begin
                if (col_cnt == 2'd2) begin
                    col_cnt <= '0;
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end else begin
                    col_cnt <= col_cnt + 2'd1;
                end
            end
            if (take_send) begin
                gap_cnt <= gap_cycles;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            if (gap_done) begin
                phase_q <= phase_q + 16'd1;
            end
        end
    end

    logic               chase_hit;
    logic [COLOR_W-1:0] ramp_lvl;
    logic [COLOR_W-1:0] pat_lvl;
    logic [COLOR_W-1:0] out_lvl;

    assign chase_hit = (32'(pix_cnt) == (32'(phase_q) % 32'(NUM_PIXELS)))
                       && (32'(col_cnt) == (32'(phase_q) % 32'd3));
    assign ramp_lvl  = base_q + COLOR_W'({pix_cnt, 3'b000})
                       + COLOR_W'({col_cnt, 5'b00000}) + COLOR_W'(phase_q);

    always_comb begin
        pat_lvl = '0;
        unique case (mode_q)
            2'd0: pat_lvl = base_q;
            2'd1: if (chase_hit) pat_lvl = base_q;
            2'd2: pat_lvl = ramp_lvl;
            2'd3: if (!phase_q[0]) pat_lvl = base_q;
            default: pat_lvl = '0;
        endcase
    end

`ifdef DIM_EN
    assign out_lvl = (32'(dim_shift) >= COLOR_W) ? '0 : (pat_lvl >> dim_shift);
`else
    logic dim_unused;
    assign dim_unused = ^dim_shift;
    assign out_lvl    = pat_lvl;
`endif

    logic               load_d;
    logic               send_d;
    logic [PIX_W-1:0]   pix_d;
    logic [1:0]         col_d;
    logic [COLOR_W-1:0] lvl_d;

    always_comb begin
        load_d = take_load;
        send_d = take_send;
        pix_d  = '0;
        col_d  = '0;
        lvl_d  = '0;
        if (take_load) begin
            pix_d = pix_cnt;
            col_d = col_cnt;
            lvl_d = out_lvl;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_color  <= 1'b0;
            send_it     <= 1'b0;
            frame_done  <= 1'b0;
            pixel_index <= '0;
            color_index <= '0;
            color_level <= '0;
        end else begin
            load_color  <= load_d;
            send_it     <= send_d;
            frame_done  <= send_d;
            pixel_index <= pix_d;
            color_index <= col_d;
            color_level <= lvl_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_neo_pattern_gen.sv
// tb_neo_pattern_gen: randomized frame checks of neo_pattern_gen against a pattern model.
// Define DIM_EN for both files to exercise the dimming path.
module tb_neo_pattern_gen;

    localparam int NP = 4;
    localparam int CW = 8;
    localparam int PW = 2;
    localparam int GW = 16;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [1:0]    mode;
    logic [CW-1:0] base_level;
    logic [GW-1:0] gap_cycles;
    logic [2:0]    dim_shift;
    logic          ready_to_load;
    logic          ready_to_send;
    logic [PW-1:0] pixel_index;
    logic [1:0]    color_index;
    logic [CW-1:0] color_level;
    logic          load_color;
    logic          send_it;
    logic          frame_done;
    logic [15:0]   phase;

    neo_pattern_gen #(
        .NUM_PIXELS(NP),
        .COLOR_W(CW),
        .GAP_W(GW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .mode(mode),
        .base_level(base_level),
        .gap_cycles(gap_cycles),
        .dim_shift(dim_shift),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send),
        .pixel_index(pixel_index),
        .color_index(color_index),
        .color_level(color_level),
        .load_color(load_color),
        .send_it(send_it),
        .frame_done(frame_done),
        .phase(phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int p;
        int c;
        int lvl;
        int cyc;
    } ld_t;

    ld_t lq[$];
    int  sq[$];
    int  cyc;
    int  zero_bad;
    int  fd_bad;
    bit  rdy_hist[32768];
    int  checks;
    int  errors;

    always @(negedge clock) begin
        rdy_hist[cyc % 32768] = ready_to_load;
        if (load_color === 1'b1) begin
            lq.push_back('{int'(pixel_index), int'(color_index),
                           int'(color_level), cyc});
        end else if (pixel_index !== '0 || color_index !== '0
                     || color_level !== '0) begin
            zero_bad++;
        end
        if (send_it === 1'b1) sq.push_back(cyc);
        if (frame_done !== send_it) fd_bad++;
        cyc++;
    end

    function automatic int exp_lvl(int m, int l, int p, int c, int ph, int ds);
        int v;
        case (m)
            0: v = l;
            1: v = (p == ph % NP && c == ph % 3) ? l : 0;
            2: v = (l + p * 8 + c * 32 + ph) % 256;
            default: v = (ph % 2 == 0) ? l : 0;
        endcase
`ifdef DIM_EN
        v = (ds >= CW) ? 0 : (v >> ds);
`else
        if (ds < 0) v = 0;
`endif
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        ready_to_load = 1'b0;
        ready_to_send = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        lq.delete();
        sq.delete();
    endtask

    // rmode: 0 hold readies, 1 random readies, 2 load-ready low on loop cycles 5,6
    task automatic run_frames(input int nf, input int budget, input int rmode,
                              output bit ok);
        int tail;
        tail = -1;
        ok = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (rmode == 1) begin
                ready_to_load = ($urandom_range(0, 99) < 60);
                ready_to_send = ($urandom_range(0, 99) < 50);
            end else if (rmode == 2) begin
                ready_to_load = !(i == 5 || i == 6);
                ready_to_send = 1'b1;
            end
            if (lq.size() >= (nf - 1) * 3 * NP + 1) enable = 1'b0;
            if (sq.size() >= nf && tail < 0) tail = int'(gap_cycles) + 4;
            else if (tail > 0) tail--;
            if (tail == 0) begin
                ok = 1'b1;
                break;
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        mode = 2'd0;
        base_level = 8'hFF;
        gap_cycles = '0;
        dim_shift = '0;
        @(negedge clock);
        checks++;
        if (load_color !== 1'b0 || send_it !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: load %b send %b done %b, required 0 0 0",
                     load_color, send_it, frame_done);
        end
        checks++;
        if (pixel_index !== '0 || color_index !== '0 || color_level !== '0) begin
            errors++;
            $display("FAIL reset_data: p %0d c %0d lvl %h, required 0 0 00",
                     pixel_index, color_index, color_level);
        end
        checks++;
        if (phase !== 16'd0) begin
            errors++;
            $display("FAIL reset_phase: got %0d, required 0", phase);
        end
        #1 reset = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (load_color !== 1'b0 || send_it !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: load %b send %b, required 0 0",
                     load_color, send_it);
        end
    endtask

    task automatic test_solid();
        bit ok;
        mode = 2'd0;
        base_level = 8'h40;
        gap_cycles = 16'd2;
        dim_shift = 3'd0;
        do_reset();
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        run_frames(1, 300, 0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL solid_timeout: done %0d, required 1", ok);
        end
        checks++;
        if (lq.size() !== 12) begin
            errors++;
            $display("FAIL solid_count: got %0d strobes, required 12", lq.size());
        end
        for (int k = 0; k < lq.size() && k < 12; k++) begin
            checks++;
            if (lq[k].p !== k / 3 || lq[k].c !== k % 3 || lq[k].lvl !== 'h40
                || lq[k].cyc !== lq[0].cyc + k) begin
                errors++;
                $display("FAIL solid_load[%0d]: got p%0d c%0d lvl %h cyc %0d, required p%0d c%0d lvl 40 cyc %0d",
                         k, lq[k].p, lq[k].c, lq[k].lvl, lq[k].cyc,
                         k / 3, k % 3, lq[0].cyc + k);
            end
        end
        checks++;
        if (sq.size() !== 1 || (lq.size() > 0 && sq.size() > 0
                                && sq[0] <= lq[lq.size() - 1].cyc)) begin
            errors++;
            $display("FAIL solid_send: got %0d sends, required 1 after last load",
                     sq.size());
        end
        checks++;
        if (phase !== 16'd1) begin
            errors++;
            $display("FAIL solid_phase: got %0d, required 1", phase);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int l;
        l = $urandom_range(0, 255);
        mode = 2'd2;
        base_level = 8'(l);
        gap_cycles = 16'd0;
        dim_shift = 3'd0;
        do_reset();
        run_frames(1, 300, 2, ok);
        checks++;
        if (!ok || lq.size() !== 12) begin
            errors++;
            $display("FAIL bp_count: done %0d strobes %0d, required 1 12",
                     ok, lq.size());
        end
        for (int k = 0; k < lq.size() && k < 12; k++) begin
            checks++;
            if (lq[k].p !== k / 3 || lq[k].c !== k % 3
                || lq[k].lvl !== exp_lvl(2, l, k / 3, k % 3, 0, 0)
                || rdy_hist[(lq[k].cyc - 1) % 32768] !== 1'b1) begin
                errors++;
                $display("FAIL bp_load[%0d]: got p%0d c%0d lvl %h rdy %b, required p%0d c%0d lvl %h rdy 1",
                         k, lq[k].p, lq[k].c, lq[k].lvl,
                         rdy_hist[(lq[k].cyc - 1) % 32768], k / 3, k % 3,
                         exp_lvl(2, l, k / 3, k % 3, 0, 0));
            end
        end
        checks++;
        if (lq.size() == 12 && lq[11].cyc - lq[0].cyc !== 13) begin
            errors++;
            $display("FAIL bp_span: got %0d cycles, required 13",
                     lq[11].cyc - lq[0].cyc);
        end
    endtask

    task automatic test_random();
        bit ok;
        int m;
        int l;
        int ds;
        int nf;
        for (int r = 0; r < 8; r++) begin
            m = $urandom_range(0, 3);
            l = $urandom_range(0, 255);
            ds = $urandom_range(0, 7);
            nf = $urandom_range(1, 3);
            mode = 2'(m);
            base_level = 8'(l);
            dim_shift = 3'(ds);
            gap_cycles = 16'($urandom_range(0, 7));
            do_reset();
            run_frames(nf, 2000, 1, ok);
            checks++;
            if (!ok || lq.size() !== nf * 12 || sq.size() !== nf) begin
                errors++;
                $display("FAIL rnd%0d_count: done %0d strobes %0d sends %0d, required 1 %0d %0d",
                         r, ok, lq.size(), sq.size(), nf * 12, nf);
            end
            for (int k = 0; k < lq.size() && k < nf * 12; k++) begin
                checks++;
                if (lq[k].p !== (k % 12) / 3 || lq[k].c !== k % 3
                    || lq[k].lvl !== exp_lvl(m, l, (k % 12) / 3, k % 3, k / 12, ds)
                    || rdy_hist[(lq[k].cyc - 1) % 32768] !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd%0d_load[%0d]: got p%0d c%0d lvl %h, required p%0d c%0d lvl %h (mode %0d)",
                             r, k, lq[k].p, lq[k].c, lq[k].lvl, (k % 12) / 3,
                             k % 3, exp_lvl(m, l, (k % 12) / 3, k % 3, k / 12, ds), m);
                end
            end
            checks++;
            if (phase !== 16'(nf)) begin
                errors++;
                $display("FAIL rnd%0d_phase: got %0d, required %0d", r, phase, nf);
            end
        end
    endtask

    task automatic test_chase();
        bit ok;
        int ep[6] = '{0, 1, 2, 3, 0, 1};
        int ec[6] = '{0, 1, 2, 0, 1, 2};
        int hits;
        int hp;
        int hc;
        mode = 2'd1;
        base_level = 8'hFF;
        gap_cycles = 16'd1;
        dim_shift = 3'd0;
        do_reset();
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        run_frames(6, 1000, 0, ok);
        checks++;
        if (!ok || lq.size() !== 72) begin
            errors++;
            $display("FAIL chase_count: done %0d strobes %0d, required 1 72",
                     ok, lq.size());
        end
        for (int f = 0; f < 6 && lq.size() >= 72; f++) begin
            hits = 0;
            hp = -1;
            hc = -1;
            for (int k = 0; k < 12; k++) begin
                if (lq[f * 12 + k].lvl != 0) begin
                    hits++;
                    hp = lq[f * 12 + k].p;
                    hc = lq[f * 12 + k].c;
                end
            end
            checks++;
            if (hits !== 1 || hp !== ep[f] || hc !== ec[f]) begin
                errors++;
                $display("FAIL chase_ph%0d: got %0d hits at p%0d c%0d, required 1 at p%0d c%0d",
                         f, hits, hp, hc, ep[f], ec[f]);
            end
        end
    endtask

    task automatic test_blink_gap();
        bit ok;
        int want;
        mode = 2'd3;
        base_level = 8'hFF;
        gap_cycles = 16'd5;
        dim_shift = 3'd0;
        do_reset();
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        run_frames(3, 1000, 0, ok);
        checks++;
        if (!ok || lq.size() !== 36 || sq.size() !== 3) begin
            errors++;
            $display("FAIL blink_count: done %0d strobes %0d sends %0d, required 1 36 3",
                     ok, lq.size(), sq.size());
        end
        for (int k = 0; k < lq.size() && k < 36; k++) begin
            want = ((k / 12) % 2 == 0) ? 'hFF : 0;
            checks++;
            if (lq[k].lvl !== want) begin
                errors++;
                $display("FAIL blink_lvl[%0d]: got %h, required %h", k, lq[k].lvl, want);
            end
        end
        for (int f = 0; f < 2 && lq.size() >= 36 && sq.size() >= 2; f++) begin
            checks++;
            if (lq[(f + 1) * 12].cyc - sq[f] !== 7) begin
                errors++;
                $display("FAIL blink_gap%0d: got %0d cycles send->load, required 7",
                         f, lq[(f + 1) * 12].cyc - sq[f]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int l;
        int n;
        l = $urandom_range(0, 255);
        mode = 2'd2;
        base_level = 8'(l);
        gap_cycles = 16'd3;
        dim_shift = 3'd0;
        do_reset();
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        enable = 1'b1;
        n = 0;
        while (lq.size() < 6 && n < 200) begin
            @(posedge clock);
            #1 n++;
        end
        enable = 1'b0;
        mode = 2'd0;
        base_level = 8'(~l);
        repeat (60) @(posedge clock);
        #1;
        checks++;
        if (lq.size() !== 12 || sq.size() !== 1) begin
            errors++;
            $display("FAIL drop_count: strobes %0d sends %0d, required 12 1",
                     lq.size(), sq.size());
        end
        for (int k = 0; k < lq.size() && k < 12; k++) begin
            checks++;
            if (lq[k].lvl !== exp_lvl(2, l, k / 3, k % 3, 0, 0)) begin
                errors++;
                $display("FAIL drop_lvl[%0d]: got %h, required %h",
                         k, lq[k].lvl, exp_lvl(2, l, k / 3, k % 3, 0, 0));
            end
        end
        checks++;
        if (phase !== 16'd1) begin
            errors++;
            $display("FAIL drop_phase: got %0d, required 1", phase);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 2'd0;
        base_level = 8'hFF;
        gap_cycles = 16'd0;
        dim_shift = 3'd0;
        do_reset();
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        enable = 1'b1;
        n = 0;
        while (lq.size() < 5 && n < 200) begin
            @(posedge clock);
            #1 n++;
        end
        enable = 1'b0;
        checks++;
        if (load_color !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: load %b, required 1", load_color);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (load_color !== 1'b0 || color_level !== '0 || pixel_index !== '0
            || color_index !== '0 || send_it !== 1'b0 || phase !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: load %b lvl %h p %0d c %0d send %b ph %0d, required all 0",
                     load_color, color_level, pixel_index, color_index, send_it, phase);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        checks++;
        if (sq.size() !== 0 || lq.size() >= 12) begin
            errors++;
            $display("FAIL rstmid_abort: sends %0d strobes %0d, required 0 and <12",
                     sq.size(), lq.size());
        end
    endtask

`ifdef DIM_EN
    task automatic test_dim();
        bit ok;
        int want;
        for (int s = 0; s < 2; s++) begin
            mode = 2'd0;
            base_level = 8'h80;
            gap_cycles = 16'd0;
            dim_shift = (s == 0) ? 3'd3 : 3'd7;
            want = (s == 0) ? 'h10 : 'h01;
            do_reset();
            ready_to_load = 1'b1;
            ready_to_send = 1'b1;
            run_frames(1, 300, 0, ok);
            checks++;
            if (!ok || lq.size() !== 12) begin
                errors++;
                $display("FAIL dim%0d_count: done %0d strobes %0d, required 1 12",
                         s, ok, lq.size());
            end
            for (int k = 0; k < lq.size() && k < 12; k++) begin
                checks++;
                if (lq[k].lvl !== want) begin
                    errors++;
                    $display("FAIL dim%0d_lvl[%0d]: got %h, required %h",
                             s, k, lq[k].lvl, want);
                end
            end
        end
    endtask
`endif

    task automatic test_invariants();
        checks++;
        if (zero_bad !== 0) begin
            errors++;
            $display("FAIL idle_zero: %0d cycles with data while load low, required 0",
                     zero_bad);
        end
        checks++;
        if (fd_bad !== 0) begin
            errors++;
            $display("FAIL frame_done_pulse: %0d cycles differing from send_it, required 0",
                     fd_bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        zero_bad = 0;
        fd_bad = 0;
        test_reset();
        test_solid();
        test_backpressure();
        test_random();
        test_chase();
        test_blink_gap();
        test_enable_drop();
        test_reset_mid();
`ifdef DIM_EN
        test_dim();
`endif
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
